// File: rtl/tile_cmd_sequencer.sv
// Tile command sequencer: queues descriptors in a small FIFO and expands each
// one into repeat+1 command flits toward the tile controller. It also captures
// response flits and keeps saturating flit/response counters.
module tile_cmd_sequencer #(
  parameter int unsigned NOC_FLIT_W = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NOC_FLIT_W+7:0]         desc_in,
  input  logic                          desc_valid,
  output logic                          desc_ready,
  output logic [NOC_FLIT_W-1:0]         ctrl_flit_out,
  output logic                          ctrl_valid_out,
  input  logic                          ctrl_ready_in,
  input  logic [NOC_FLIT_W-1:0]         resp_flit_in,
  input  logic                          resp_valid_in,
  input  logic                          cnt_clear,
  output logic [NOC_FLIT_W-1:0]         resp_flit_last,
  output logic [15:0]                   flit_count,
  output logic [15:0]                   resp_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          seq_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LevelFull = (AW+1)'(FIFO_DEPTH);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  logic [NOC_FLIT_W+7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           level_q;
  logic [0:0]            state_q, state_d;
  logic [7:0]            rep_q, rep_d;
  logic [NOC_FLIT_W-1:0] flit_q, flit_d;
  logic [NOC_FLIT_W-1:0] resp_last_q;
  logic [15:0]           flit_cnt_q, resp_cnt_q;
  logic                  push, pop, hs;
  logic [NOC_FLIT_W+7:0] head;
  logic                  fifo_nonempty;

  assign desc_ready     = (level_q != LevelFull);
  assign fifo_nonempty  = (level_q != '0);
  assign push           = desc_valid && desc_ready && !rst;
  assign head           = mem_q[rd_ptr_q];
  assign ctrl_valid_out = (state_q == StIssue);
  assign hs             = ctrl_valid_out && ctrl_ready_in;

  // Issue FSM next-state: pop/load descriptors and walk the repeat counter
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    flit_d  = flit_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          flit_d  = head[NOC_FLIT_W-1:0];
          rep_d   = head[NOC_FLIT_W +: 8];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (ctrl_ready_in) begin
          if (rep_q != 8'd0) begin
            rep_d = rep_q - 8'd1;
            // Bank-address stepping only for the two burst opcodes
            if (flit_q[63:56] == 8'h10 || flit_q[63:56] == 8'h11) begin
              flit_d[47:36] = flit_q[47:36] + 12'd1;
            end
          end else if (fifo_nonempty) begin
            pop    = 1'b1;
            flit_d = head[NOC_FLIT_W-1:0];
            rep_d  = head[NOC_FLIT_W +: 8];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Descriptor storage; pointers reset separately, contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= desc_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + (AW+1)'(1);
      else if (pop && !push) level_q <= level_q - (AW+1)'(1);
    end
  end

  // FSM state, repeat counter and outgoing flit register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rep_q   <= 8'd0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      flit_q  <= flit_d;
    end
  end

  // Response capture and saturating counters; clear beats increment
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_last_q <= '0;
      flit_cnt_q  <= 16'd0;
      resp_cnt_q  <= 16'd0;
    end else begin
      if (resp_valid_in) resp_last_q <= resp_flit_in;
      if (cnt_clear) begin
        flit_cnt_q <= 16'd0;
        resp_cnt_q <= 16'd0;
      end else begin
        if (hs && flit_cnt_q != 16'hFFFF)            flit_cnt_q <= flit_cnt_q + 16'd1;
        if (resp_valid_in && resp_cnt_q != 16'hFFFF) resp_cnt_q <= resp_cnt_q + 16'd1;
      end
    end
  end

  assign ctrl_flit_out  = flit_q;
  assign resp_flit_last = resp_last_q;
  assign flit_count     = flit_cnt_q;
  assign resp_count     = resp_cnt_q;
  assign fifo_level     = level_q;
  assign seq_busy       = (state_q == StIssue) || fifo_nonempty;

endmodule

// File: tb/tb_tile_cmd_sequencer.sv
// Bench for tile_cmd_sequencer: scoreboard of expected flits fed at push time,
// a descriptor vector table, and hand-written reset/stall/saturation sequences.
module tb_tile_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] desc_in;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] ctrl_flit_out;
  logic        ctrl_valid_out;
  logic        ctrl_ready_in;
  logic [63:0] resp_flit_in;
  logic        resp_valid_in;
  logic        cnt_clear;
  logic [63:0] resp_flit_last;
  logic [15:0] flit_count;
  logic [15:0] resp_count;
  logic [2:0]  fifo_level;
  logic        seq_busy;

  tile_cmd_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .desc_in        (desc_in),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .ctrl_flit_out  (ctrl_flit_out),
    .ctrl_valid_out (ctrl_valid_out),
    .ctrl_ready_in  (ctrl_ready_in),
    .resp_flit_in   (resp_flit_in),
    .resp_valid_in  (resp_valid_in),
    .cnt_clear      (cnt_clear),
    .resp_flit_last (resp_flit_last),
    .flit_count     (flit_count),
    .resp_count     (resp_count),
    .fifo_level     (fifo_level),
    .seq_busy       (seq_busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          hs_cnt   = 0;
  logic        sb_en    = 1'b1;
  logic [63:0] exp_q[$];
  logic [63:0] last_flit = '0;
  logic        held_v    = 1'b0;
  logic [63:0] held_flit = '0;

  typedef struct {
    logic [7:0]  rep;
    logic [63:0] flit;
    int unsigned exp_n;
    logic [15:0] exp_last;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on handshake, hold-stability while stalled
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else if (sb_en) begin
      if (ctrl_valid_out && held_v) check("stall_hold", ctrl_flit_out, held_flit);
      if (ctrl_valid_out && ctrl_ready_in) begin
        hs_cnt++;
        last_flit = ctrl_flit_out;
        held_v    = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got %h expected none", ctrl_flit_out);
        end else begin
          check("sb_flit", ctrl_flit_out, exp_q.pop_front());
        end
      end else if (ctrl_valid_out) begin
        held_v    = 1'b1;
        held_flit = ctrl_flit_out;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic push_desc(input logic [7:0] rep, input logic [63:0] flit);
    logic [63:0] f;
    for (int c = 0; c < 4000 && !desc_ready; c++) tick();
    check("push_ready", desc_ready, 1);
    desc_in    = {rep, flit};
    desc_valid = 1'b1;
    if (sb_en) begin
      f = flit;
      for (int k = 0; k <= int'(rep); k++) begin
        exp_q.push_back(f);
        if (f[63:56] == 8'h10 || f[63:56] == 8'h11) f[47:36] = f[47:36] + 12'd1;
      end
    end
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 4000 && seq_busy; c++) tick();
    check("idle_wait", seq_busy, 0);
    if (sb_en) check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] base;
    int          hbase;

    vecs[0] = '{8'd3, {8'h11, 8'h05, 16'hFFF1, 32'hDEADBEEF}, 4, 16'h0021};
    vecs[1] = '{8'd2, {8'h10, 8'h01, 16'h0120, 32'h00000001}, 3, 16'h0140};
    vecs[2] = '{8'd2, {8'h20, 8'h02, 16'h0120, 32'h00000002}, 3, 16'h0120};
    vecs[3] = '{8'd0, {8'h11, 8'h03, 16'hABCD, 32'h00000003}, 1, 16'hABCD};
    vecs[4] = '{8'd1, {8'h10, 8'h04, 16'hFFFF, 32'h00000004}, 2, 16'h000F};

    rst = 1'b1; desc_in = '0; desc_valid = 1'b0; ctrl_ready_in = 1'b1;
    resp_flit_in = '0; resp_valid_in = 1'b0; cnt_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_valid", ctrl_valid_out, 0);
    check("rst_ready", desc_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_busy", seq_busy, 0);
    check("rst_flit", ctrl_flit_out, 0);
    check("rst_fcnt", flit_count, 0);
    check("rst_rcnt", resp_count, 0);
    check("rst_rlast", resp_flit_last, 0);

    // Single flit, latency E+1
    push_desc(8'd0, 64'h0400_00A5_0000_0000);
    check("lat_e_valid", ctrl_valid_out, 0);
    check("lat_e_level", fifo_level, 1);
    tick();
    check("lat_e1_valid", ctrl_valid_out, 1);
    check("lat_e1_flit", ctrl_flit_out, 64'h0400_00A5_0000_0000);
    wait_idle();
    check("single_fcnt", flit_count, 1);

    // Vector table
    for (int i = 0; i < 5; i++) begin
      base = flit_count;
      push_desc(vecs[i].rep, vecs[i].flit);
      wait_idle();
      check("vec_count", 64'(flit_count - base), 64'(vecs[i].exp_n));
      check("vec_last_data", last_flit[47:32], vecs[i].exp_last);
    end

    // Fill while stalled, then release: back-to-back, in order
    ctrl_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) push_desc(8'd0, {8'h20, 8'(i), 16'h1000, 32'(i * 7)});
    check("full_level", fifo_level, 4);
    check("full_ready", desc_ready, 0);
    check("full_busy", seq_busy, 1);
    repeat (3) tick();
    check("stall_first", ctrl_flit_out, {8'h20, 8'h00, 16'h1000, 32'h0});
    ctrl_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_bubble", ctrl_valid_out, 1);
    end
    #1;
    wait_idle();

    // Reset mid-burst, with a queued descriptor and ignored inputs during rst
    hbase = hs_cnt;
    push_desc(8'd5, {8'h20, 8'h09, 16'h2222, 32'h0});
    push_desc(8'd0, {8'h20, 8'h0A, 16'h3333, 32'h0});
    for (int c = 0; c < 50 && hs_cnt < hbase + 2; c++) tick();
    check("burst_two", hs_cnt - hbase, 2);
    rst = 1'b1; desc_valid = 1'b1; desc_in = {8'd0, 64'h2000_1111_2222_3333};
    resp_valid_in = 1'b1; resp_flit_in = 64'hDEAD;
    tick();
    rst = 1'b0; desc_valid = 1'b0; resp_valid_in = 1'b0;
    exp_q.delete();
    hbase = hs_cnt;
    check("mid_rst_valid", ctrl_valid_out, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_fcnt", flit_count, 0);
    check("mid_rst_rcnt", resp_count, 0);
    check("mid_rst_rlast", resp_flit_last, 0);
    check("mid_rst_busy", seq_busy, 0);
    repeat (10) tick();
    check("mid_rst_quiet", hs_cnt - hbase, 0);

    // Response capture and clear priority
    resp_valid_in = 1'b1; resp_flit_in = 64'h1234;
    tick();
    check("resp1_last", resp_flit_last, 64'h1234);
    check("resp1_cnt", resp_count, 1);
    resp_flit_in = 64'hABCD;
    tick();
    resp_valid_in = 1'b0;
    check("resp2_last", resp_flit_last, 64'hABCD);
    check("resp2_cnt", resp_count, 2);
    resp_valid_in = 1'b1; resp_flit_in = 64'h5555; cnt_clear = 1'b1;
    tick();
    resp_valid_in = 1'b0; cnt_clear = 1'b0;
    check("resp_clr_cnt", resp_count, 0);
    check("resp_clr_last", resp_flit_last, 64'h5555);

    // Saturation: 65536 flits drive flit_count to 0xFFFF
    sb_en = 1'b0;
    for (int i = 0; i < 256; i++) push_desc(8'd255, {8'h20, 8'h00, 16'h0000, 32'(i)});
    wait_idle();
    sb_en = 1'b1;
    check("sat_reach", flit_count, 16'hFFFF);
    push_desc(8'd0, 64'h2000_0001_0000_0000);
    wait_idle();
    check("sat_hold", flit_count, 16'hFFFF);
    ctrl_ready_in = 1'b0;
    push_desc(8'd0, 64'h2000_0002_0000_0000);
    tick();
    check("clr_valid", ctrl_valid_out, 1);
    cnt_clear = 1'b1; ctrl_ready_in = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("clr_wins", flit_count, 0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
